myproject_mul_rr_sched: RTL and testbench
=========================================

# myproject_mul_rr_sched

Round-robin scheduler that shares one signed-by-unsigned multiplier (32-bit signed × 5-bit unsigned → 37-bit signed) among `NREQ` requesters in the VAE dense-layer datapath. Each cycle it picks at most one pending request and drives its operands into the combinational multiplier. It registers the product with the winner's index and holds the result until the consumer accepts it. This lets several layer lanes reuse a single DSP/LUT multiplier instead of instantiating one each.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..16.
- `DIN0_W`, default 32: signed operand width.
- `DIN1_W`, default 5: unsigned operand width.
- `DOUT_W`, default 37: product width, equal to `DIN0_W + DIN1_W`.
- `CNT_W`, default 16: grant counter width.

Ports:
- `ap_clk`, in, 1: clock. Everything is on the rising edge.
- `ap_rst`, in, 1: reset. Asynchronous, active-high.
- `req_valid`, in, `NREQ`: bit i set means requester i has operands pending.
- `req_ready`, out, `NREQ`: one-hot or zero. Bit i set means requester i's operands are taken this cycle.
- `req_din0`, in, `NREQ*DIN0_W`: signed operands. Requester i occupies slice `[i*DIN0_W +: DIN0_W]`.
- `req_din1`, in, `NREQ*DIN1_W`: unsigned operands, packed the same way.
- `rsp_valid`, out, 1: a result is held.
- `rsp_id`, out, `$clog2(NREQ)`: index of the requester that owns the held result.
- `rsp_dout`, out, `DOUT_W`: held signed product.
- `rsp_ready`, in, 1: consumer accepts the held result this cycle.
- `grant_cnt`, out, `CNT_W`: total number of grants. Wraps modulo 2^`CNT_W`.

## Operation
- `can_issue = !rsp_valid || rsp_ready`. A single-entry output register is the only buffering.
- Arbitration:
  - `ptr` holds the last granted index.
  - Search order is `ptr+1, ptr+2, …` modulo `NREQ`. The first index with `req_valid` set wins.
  - `req_ready[win] = can_issue && |req_valid`. All other bits are 0.
  - `req_ready` depends combinationally on `req_valid`.
  - A requester must hold `req_valid` and its operands stable until it sees `req_ready`.
- On a grant (any `req_ready` bit set):
  - `ptr ← win`.
  - `rsp_dout ← din0 × zero-extended din1`, computed as an exact 37-bit signed result. Overflow is impossible.
  - `rsp_id ← win`.
  - `rsp_valid ← 1`.
  - `grant_cnt ← grant_cnt + 1`.
- On `rsp_ready && rsp_valid` with no grant in the same cycle: `rsp_valid ← 0`.
  - `rsp_dout` and `rsp_id` keep their last values.
- Simultaneous drain and grant: the new result replaces the old one in the same edge and `rsp_valid` stays 1. This gives full throughput of one product per cycle.
- `rsp_ready` while `rsp_valid = 0` is ignored.
- No pending requests: `ptr` is unchanged and no grant occurs.
- Full (`rsp_valid && !rsp_ready`): no grants, `ptr` is frozen, and held outputs are stable.
- Reset values:
  - `rsp_valid = 0`, `rsp_id = 0`, `rsp_dout = 0`, `grant_cnt = 0`.
  - `ptr = NREQ-1`, so requester 0 has first priority.
  - `req_ready` is 0 while `ap_rst` is high.
- Reset during operation discards any held result. Requesters keep their `req_valid` asserted and are re-served after reset is released.

## Timing
- Latency is one cycle. Operands are accepted at edge k; `rsp_valid`, `rsp_id` and `rsp_dout` are visible from edge k to edge k+1 onward.
- Throughput is one grant per cycle while the consumer keeps `rsp_ready` at 1.
- With all requesters active, each requester waits at most `NREQ-1` grants.
- Combinational paths:
  - `req_valid`/`rsp_valid`/`rsp_ready` → `req_ready`.
  - operand mux → multiplier → `rsp_dout` register D input.
- There is no combinational path from inputs to `rsp_*` outputs.

## Structure
- Package `myproject_mul_sched_pkg` holds:
  - the `DIN0_W`, `DIN1_W` and `DOUT_W` constants;
  - the `id_t` typedef (`$clog2(NREQ)` bits);
  - the round-robin pick function, taking `req_valid` and `ptr` and returning the winner index and an any-valid flag.
- Single sub-module: the existing `myproject_mul_32s_5ns_37_1_1`, instantiated once as the only arithmetic resource. Its inputs are the muxed `din0`/`din1` of the winner.
- The top level contains the operand mux, arbiter pointer, output register and counter.

## Test plan
- Reset, then single request: requester 2 with din0 = −3, din1 = 31 → `req_ready = 4'b0100` in the same cycle. Next cycle: `rsp_valid = 1`, `rsp_id = 2`, `rsp_dout = 37'h1FFFFFFFA3` (−93), `grant_cnt = 1`.
- Extremes with `rsp_ready = 1`:
  - din0 = 32'h7FFFFFFF, din1 = 31 → `37'h0F7FFFFFE1`;
  - din0 = 32'h80000000, din1 = 31 → `37'h1080000000`;
  - din1 = 0 → 0.
- All 4 requesters valid continuously with `rsp_ready = 1` → grant order 0,1,2,3,0,1 on consecutive cycles, with one result per cycle.
- Backpressure: result held and `rsp_ready = 0` for 3 cycles while requests are pending:
  - `req_ready` stays 0;
  - `rsp_dout` and `rsp_id` are stable;
  - `ptr` is frozen;
  - raising `rsp_ready` gives a grant in the same cycle, and the new result appears next cycle with `rsp_valid` continuously 1.
- Reset during operation:
  - assert `ap_rst` asynchronously while `rsp_valid = 1` → all outputs go to reset values immediately, without waiting for a clock edge;
  - after release, requests 1 and 3 pending → grant goes to 1 first.
- Counter wrap: `CNT_W = 4`, 17 grants → `grant_cnt = 1`.

Source files
------------

// File: rtl/myproject_mul_rr_sched_pkg.sv
// Shared constants, id type and round-robin pick function for the multiplier scheduler.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package myproject_mul_sched_pkg;

  localparam int DIN0_W   = 32;
  localparam int DIN1_W   = 5;
  localparam int DOUT_W   = DIN0_W + DIN1_W;
  localparam int NREQ_DEF = 4;
  localparam int NREQ_MAX = 16;

  typedef logic [$clog2(NREQ_DEF)-1:0] id_t;

  typedef struct packed {
    logic       any;
    logic [3:0] win;
  } pick_t;

  // Search ptr+1, ptr+2, ... modulo n; the nearest valid index wins. The loop runs
  // from the farthest offset to the nearest so the nearest hit is written last.
  function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] valid,
                                    input logic [3:0]          ptr,
                                    input int                  n);
    pick_t res;
    int    idx;
    res = '0;
    for (int k = NREQ_MAX; k >= 1; k--) begin
      if (k <= n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx[3:0]]) begin
          res.any = 1'b1;
          res.win = idx[3:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/myproject_mul_rr_sched_if.sv
// Request/response bundle between requesters, consumer and the multiplier scheduler.
// Latency: n/a (wires only).
// Backpressure: req_ready per requester, rsp_ready from the consumer.
interface myproject_mul_rr_sched_if #(
  parameter int NREQ   = 4,
  parameter int DIN0_W = 32,
  parameter int DIN1_W = 5,
  parameter int DOUT_W = 37,
  parameter int CNT_W  = 16
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DIN0_W-1:0] req_din0;
  logic [NREQ*DIN1_W-1:0] req_din1;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [DOUT_W-1:0]      rsp_dout;
  logic                   rsp_ready;
  logic [CNT_W-1:0]       grant_cnt;

  modport master (
    output req_valid, req_din0, req_din1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_dout, grant_cnt
  );

  modport slave (
    input  req_valid, req_din0, req_din1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_dout, grant_cnt
  );

endinterface

// File: rtl/myproject_mul_32s_5ns_37_1_1.sv
// Combinational signed x unsigned multiplier (32s x 5u -> 37s), exact result.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module myproject_mul_32s_5ns_37_1_1 #(
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 5,
  parameter int dout_WIDTH = 37
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  logic signed [dout_WIDTH-1:0] a_ext;
  logic signed [dout_WIDTH-1:0] b_ext;

  // din0 is sign-extended, din1 zero-extended, so the truncated product is exact.
  assign a_ext = dout_WIDTH'($signed(din0));
  assign b_ext = dout_WIDTH'({1'b0, din1});
  assign dout  = a_ext * b_ext;

endmodule

// File: rtl/myproject_mul_rr_sched.sv
// Round-robin sharing of one 32s x 5u multiplier among NREQ requesters, registered result.
// Latency: 1 cycle from grant to rsp_valid/rsp_id/rsp_dout.
// Backpressure: no grant while a held result is not being drained (rsp_valid && !rsp_ready).
module myproject_mul_rr_sched #(
  parameter int NREQ   = myproject_mul_sched_pkg::NREQ_DEF,
  parameter int DIN0_W = myproject_mul_sched_pkg::DIN0_W,
  parameter int DIN1_W = myproject_mul_sched_pkg::DIN1_W,
  parameter int DOUT_W = myproject_mul_sched_pkg::DOUT_W,
  parameter int CNT_W  = 16
) (
  input logic                     ap_clk,
  input logic                     ap_rst,
  myproject_mul_rr_sched_if.slave bus
);
  import myproject_mul_sched_pkg::*;

  localparam int ID_W = $clog2(NREQ);

  logic [ID_W-1:0]   ptr;
  pick_t             pick;
  logic [ID_W-1:0]   win;
  logic              can_issue;
  logic              grant;
  logic [DIN0_W-1:0] mux_din0;
  logic [DIN1_W-1:0] mux_din1;
  logic [DOUT_W-1:0] prod;

  // Single output register is the only buffer: issue only when it is empty or draining.
  assign can_issue = !bus.rsp_valid || bus.rsp_ready;

  // Pick the nearest pending requester after the last one granted.
  always_comb begin
    pick = rr_pick(16'(bus.req_valid), 4'(ptr), NREQ);
  end

  assign win   = pick.win[ID_W-1:0];
  assign grant = can_issue && pick.any && !ap_rst;

  // One-hot ready to the winner, zero otherwise and throughout reset.
  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[win] = 1'b1;
  end

  assign mux_din0 = bus.req_din0[int'(win)*DIN0_W +: DIN0_W];
  assign mux_din1 = bus.req_din1[int'(win)*DIN1_W +: DIN1_W];

  myproject_mul_32s_5ns_37_1_1 #(
    .din0_WIDTH(DIN0_W),
    .din1_WIDTH(DIN1_W),
    .dout_WIDTH(DOUT_W)
  ) u_mul (
    .din0(mux_din0),
    .din1(mux_din1),
    .dout(prod)
  );

  // Pointer, held result and grant counter; a grant overrides a same-cycle drain.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ptr           <= ID_W'(NREQ - 1);
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_dout  <= '0;
      bus.grant_cnt <= '0;
    end else if (grant) begin
      ptr           <= win;
      bus.rsp_valid <= 1'b1;
      bus.rsp_id    <= win;
      bus.rsp_dout  <= prod;
      bus.grant_cnt <= bus.grant_cnt + CNT_W'(1);
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_myproject_mul_rr_sched.sv
// Bench for the round-robin multiplier scheduler: directed scenarios plus random traffic
// checked against a queue-free behavioural model of arbitration and arithmetic.
// Second instance with a 4-bit counter exercises wrap-around.
module tb_myproject_mul_rr_sched;
  import myproject_mul_sched_pkg::*;

  logic ap_clk;
  logic ap_rst;

  myproject_mul_rr_sched_if #(.NREQ(4), .DIN0_W(32), .DIN1_W(5), .DOUT_W(37), .CNT_W(16)) bus();
  myproject_mul_rr_sched_if #(.NREQ(4), .DIN0_W(32), .DIN1_W(5), .DOUT_W(37), .CNT_W(4))  bus2();

  myproject_mul_rr_sched #(.NREQ(4), .DIN0_W(32), .DIN1_W(5), .DOUT_W(37), .CNT_W(16)) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus   (bus)
  );

  myproject_mul_rr_sched #(.NREQ(4), .DIN0_W(32), .DIN1_W(5), .DOUT_W(37), .CNT_W(4)) dut_wrap (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus   (bus2)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int          last;
  bit          m_valid;
  int          m_id;
  logic [36:0] m_dout;
  int          m_cnt;
  logic [3:0]  last_gnt;

  function automatic int pick_model(input logic [3:0] v, input int lst);
    int c;
    for (int off = 1; off <= 4; off++) begin
      c = (lst + off) % 4;
      if (v[c[1:0]]) return c;
    end
    return -1;
  endfunction

  function automatic logic [36:0] prod_model(input logic [31:0] a, input logic [4:0] b);
    longint p;
    p = longint'($signed(a)) * longint'(b);
    return p[36:0];
  endfunction

  function automatic logic [3:0] exp_ready();
    int w;
    logic [3:0] r;
    r = 4'b0;
    w = pick_model(bus.req_valid, last);
    if ((!m_valid || bus.rsp_ready) && w >= 0) r[w[1:0]] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    last = 3; m_valid = 0; m_id = 0; m_dout = '0; m_cnt = 0;
  endtask

  // Advance one clock edge, updating the model from the pre-edge inputs.
  task automatic tick();
    int w;
    logic [3:0]  r;
    logic [31:0] a;
    logic [4:0]  b;
    r = exp_ready();
    w = pick_model(bus.req_valid, last);
    a = '0; b = '0;
    if (w >= 0) begin
      a = bus.req_din0[w*32 +: 32];
      b = bus.req_din1[w*5 +: 5];
    end
    @(posedge ap_clk);
    if (r != 4'b0) begin
      last = w; m_id = w; m_dout = prod_model(a, b); m_valid = 1;
      m_cnt = (m_cnt + 1) % 65536;
    end else if (bus.rsp_ready) begin
      m_valid = 0;
    end
    last_gnt = r;
    #1;
  endtask

  task automatic pulse_reset();
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b0;
    #3;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
    checks++; if (bus.rsp_dout !== 37'd0) begin errors++; $display("FAIL reset_rsp_dout: got %h want 0", bus.rsp_dout); end
    checks++; if (bus.grant_cnt !== 16'd0) begin errors++; $display("FAIL reset_grant_cnt: got %0d want 0", bus.grant_cnt); end
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    @(posedge ap_clk);
    #1;
    bus.req_valid = 4'h0;
    ap_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    bus.req_din0 = '0; bus.req_din1 = '0;
    bus.req_din0[2*32 +: 32] = -32'sd3;
    bus.req_din1[2*5 +: 5]   = 5'd31;
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    #3;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0;
    #3;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d want 2", bus.rsp_id); end
    checks++; if (bus.rsp_dout !== 37'h1FFFFFFFA3) begin errors++; $display("FAIL single_dout: got %h want 1fffffffa3", bus.rsp_dout); end
    checks++; if (bus.grant_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", bus.grant_cnt); end
  endtask

  task automatic test_extremes();
    logic [31:0] a_tab [3];
    logic [4:0]  b_tab [3];
    logic [36:0] p_tab [3];
    a_tab[0] = 32'h7FFFFFFF; b_tab[0] = 5'd31; p_tab[0] = 37'h0F7FFFFFE1;
    a_tab[1] = 32'h80000000; b_tab[1] = 5'd31; p_tab[1] = 37'h1080000000;
    a_tab[2] = $urandom;     b_tab[2] = 5'd0;  p_tab[2] = 37'h0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req_din0 = '0; bus.req_din1 = '0;
      bus.req_din0[k*32 +: 32] = a_tab[k];
      bus.req_din1[k*5 +: 5]   = b_tab[k];
      bus.req_valid = 4'b0;
      bus.req_valid[k] = 1'b1;
      #3;
      checks++; if (bus.req_ready !== exp_ready()) begin errors++; $display("FAIL extreme_ready[%0d]: got %b want %b", k, bus.req_ready, exp_ready()); end
      tick();
      bus.req_valid = 4'b0;
      #3;
      checks++; if (bus.rsp_dout !== p_tab[k]) begin errors++; $display("FAIL extreme_dout[%0d]: got %h want %h", k, bus.rsp_dout, p_tab[k]); end
      checks++; if (bus.rsp_id !== 2'(k)) begin errors++; $display("FAIL extreme_id[%0d]: got %0d want %0d", k, bus.rsp_id, k); end
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_din0[i*32 +: 32] = $urandom;
      bus.req_din1[i*5 +: 5]   = 5'($urandom_range(0, 31));
    end
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #3;
      checks++; if (bus.req_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, bus.req_ready, 4'b0001 << (k % 4)); end
      tick();
      #3;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(k % 4)) begin errors++; $display("FAIL b2b_rsp[%0d]: got v=%b id=%0d want v=1 id=%0d", k, bus.rsp_valid, bus.rsp_id, k % 4); end
      checks++; if (bus.rsp_dout !== m_dout) begin errors++; $display("FAIL b2b_dout[%0d]: got %h want %h", k, bus.rsp_dout, m_dout); end
      #(-3 + 3);
    end
  endtask

  task automatic test_backpressure();
    logic [36:0] held_dout;
    int          held_id;
    held_dout = m_dout;
    held_id   = m_id;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #3;
      checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, bus.req_ready); end
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dout !== held_dout || bus.rsp_id !== 2'(held_id)) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d dout=%h want v=1 id=%0d dout=%h", k, bus.rsp_valid, bus.rsp_id, bus.rsp_dout, held_id, held_dout); end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #3;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b want 0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0;
    bus.rsp_ready = 1'b0;
    #3;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_dout !== m_dout) begin errors++; $display("FAIL bp_release_rsp: got v=%b id=%0d dout=%h want v=1 id=2 dout=%h", bus.rsp_valid, bus.rsp_id, bus.rsp_dout, m_dout); end
  endtask

  task automatic test_async_reset();
    bus.req_valid = 4'b1010;
    bus.rsp_ready = 1'b0;
    #2;
    ap_rst = 1'b1;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_dout !== 37'd0 || bus.grant_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_outputs: got v=%b id=%0d dout=%h cnt=%0d want all 0", bus.rsp_valid, bus.rsp_id, bus.rsp_dout, bus.grant_cnt); end
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL async_rst_ready: got %b want 0000", bus.req_ready); end
    @(posedge ap_clk);
    #3;
    ap_rst = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL post_rst_ready: got %b want 0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b1000;
    #3;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.grant_cnt !== 16'd1) begin errors++; $display("FAIL post_rst_rsp: got v=%b id=%0d cnt=%0d want v=1 id=1 cnt=1", bus.rsp_valid, bus.rsp_id, bus.grant_cnt); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = 4'b0;
  endtask

  task automatic test_random();
    logic [31:0] op0 [4];
    logic [4:0]  op1 [4];
    bit          pend [4];
    int          wt [4];
    for (int i = 0; i < 4; i++) begin
      pend[i] = bus.req_valid[i]; wt[i] = 0;
      op0[i] = bus.req_din0[i*32 +: 32]; op1[i] = bus.req_din1[i*5 +: 5];
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1; wt[i] = 0;
          op0[i] = $urandom;
          op1[i] = 5'($urandom_range(0, 31));
        end
        bus.req_valid[i]         = pend[i];
        bus.req_din0[i*32 +: 32] = op0[i];
        bus.req_din1[i*5 +: 5]   = op1[i];
      end
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      #3;
      checks++; if (bus.req_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", cyc, bus.req_ready, exp_ready()); end
      checks++; if (bus.rsp_valid !== m_valid || bus.rsp_id !== 2'(m_id) || bus.rsp_dout !== m_dout || bus.grant_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rand_rsp[%0d]: got v=%b id=%0d dout=%h cnt=%0d want v=%b id=%0d dout=%h cnt=%0d", cyc, bus.rsp_valid, bus.rsp_id, bus.rsp_dout, bus.grant_cnt, m_valid, m_id, m_dout, m_cnt); end
      tick();
      for (int i = 0; i < 4; i++) begin
        if (last_gnt[i]) begin
          pend[i] = 0;
        end else if (pend[i] && last_gnt != 4'b0) begin
          wt[i]++;
          checks++; if (wt[i] > 3) begin errors++; $display("FAIL rand_fairness[%0d]: requester %0d waited %0d grants, limit 3", cyc, i, wt[i]); end
        end
      end
    end
    bus.req_valid = 4'b0;
    bus.rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    pulse_reset();
    bus2.req_din0  = '0;
    bus2.req_din1  = '0;
    bus2.rsp_ready = 1'b1;
    bus2.req_valid = 4'b0001;
    for (int k = 1; k <= 17; k++) begin
      @(posedge ap_clk);
      #1;
      if (k == 16) begin
        checks++; if (bus2.grant_cnt !== 4'd0) begin errors++; $display("FAIL wrap_cnt16: got %0d want 0", bus2.grant_cnt); end
      end
    end
    bus2.req_valid = 4'b0;
    #3;
    checks++; if (bus2.grant_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt17: got %0d want 1", bus2.grant_cnt); end
  endtask

  initial begin
    ap_rst         = 1'b1;
    bus.req_valid  = '0;
    bus.req_din0   = '0;
    bus.req_din1   = '0;
    bus.rsp_ready  = 1'b0;
    bus2.req_valid = '0;
    bus2.req_din0  = '0;
    bus2.req_din1  = '0;
    bus2.rsp_ready = 1'b0;
    last_gnt       = '0;
    model_reset();
    test_reset();
    test_single();
    test_extremes();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
